// File: rtl/mux_nx1_reg_pkg.sv
// mux_pkg: shared constants and helpers for the registered N:1 mux.
//   MODE_FIXED / MODE_RR : encodings of the mode input
//   clog2()              : ceiling log2, used to size sel / out_ch / ptr
package mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Smallest r with 2**r >= n. Callers guarantee n >= 2, so r >= 1.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/mux_nx1_reg_rr_pick.sv
// rr_pick: combinational rotate-priority picker.
//   req  in  N_CH   request vector
//   ptr  in  SEL_W  index searched first; search continues upward and wraps
//   gnt  out SEL_W  first requesting index at or after ptr (0 when none)
//   any  out 1      at least one request is set
// ptr is always kept < N_CH by the owner, so one conditional subtract is
// enough to wrap the search index.
module rr_pick
  import mux_pkg::*;
#(
  parameter  int N_CH  = 8,
  localparam int SEL_W = clog2(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] gnt,
  output logic             any
);

  logic [SEL_W:0]   sum;
  logic [SEL_W-1:0] idx;

  always_comb begin
    gnt = '0;
    any = 1'b0;
    sum = '0;
    idx = '0;
    for (int k = 0; k < N_CH; k++) begin
      sum = {1'b0, ptr} + (SEL_W+1)'(k);
      if (sum >= (SEL_W+1)'(N_CH)) sum = sum - (SEL_W+1)'(N_CH);
      idx = sum[SEL_W-1:0];
      // First hit wins; later hits are ignored once any is set.
      if (!any && req[idx]) begin
        any = 1'b1;
        gnt = idx;
      end
    end
  end

endmodule

// File: rtl/mux_nx1_reg.sv
// mux_nx1_reg: N-channel, W-bit registered multiplexer with valid/ready.
//   clk, rst   rising-edge clock, synchronous active-high reset
//   in_data    N_CH*W  channel i at [i*W +: W]
//   in_valid   N_CH    per-channel valid
//   in_ready   N_CH    one-hot (or zero) accept strobe to the granted channel
//   mode       1       0 = fixed select via sel, 1 = round-robin over valids
//   sel        SEL_W   channel index for fixed mode
//   out_data   W       registered word
//   out_ch     SEL_W   channel the registered word came from
//   out_valid  1       out_data holds a word not yet taken by the consumer
//   out_ready  1       consumer accepts
//   sel_err    1       previous cycle had fixed mode with sel >= N_CH
//   xfer_cnt   CNT_W   completed output transfers, wrapping
// Single output register: a new word loads whenever the register is empty
// or is being drained this cycle, giving one word per cycle with no bubble.
module mux_nx1_reg
  import mux_pkg::*;
#(
  parameter  int N_CH  = 8,
  parameter  int W     = 1,
  parameter  int CNT_W = 16,
  localparam int SEL_W = clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH*W-1:0] in_data,
  input  logic [N_CH-1:0]   in_valid,
  output logic [N_CH-1:0]   in_ready,
  input  logic              mode,
  input  logic [SEL_W-1:0]  sel,
  output logic [W-1:0]      out_data,
  output logic [SEL_W-1:0]  out_ch,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              sel_err,
  output logic [CNT_W-1:0]  xfer_cnt
);

  localparam int PAD_N = 1 << SEL_W;

  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] rrGnt;
  logic             rrAny;
  logic [SEL_W-1:0] gnt;
  logic             gv;
  logic             selOk;
  logic [PAD_N-1:0] validPad;
  logic             free;
  logic             load;
  logic             drain;
  logic [W-1:0]     selData;

  rr_pick #(.N_CH(N_CH)) uPick (
    .req (in_valid),
    .ptr (ptr),
    .gnt (rrGnt),
    .any (rrAny)
  );

  // in_valid zero-extended to the full sel range so an out-of-range sel
  // reads a 0 instead of indexing past the vector.
  assign validPad = PAD_N'(in_valid);
  // One extra bit keeps the compare meaningful when N_CH is a power of 2.
  assign selOk    = {1'b0, sel} < (SEL_W+1)'(N_CH);

  always_comb begin
    gnt = '0;
    gv  = 1'b0;
    if (mode == MODE_RR) begin
      gnt = rrGnt;
      gv  = rrAny;
    end else begin
      gnt = sel;
      gv  = selOk & validPad[sel];
    end
  end

  assign free  = !out_valid | out_ready;
  assign load  = free & gv;
  assign drain = out_valid & out_ready;

  // Data mux by comparison rather than a variable part-select, so a sel
  // beyond N_CH never forms an out-of-range select (load is 0 then anyway).
  always_comb begin
    selData = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (gnt == SEL_W'(i)) selData = in_data[i*W +: W];
    end
  end

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N_CH; i++) begin
      in_ready[i] = load & (gnt == SEL_W'(i)) & !rst;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      sel_err   <= 1'b0;
      xfer_cnt  <= '0;
      ptr       <= '0;
    end else begin
      if (load) begin
        out_data  <= selData;
        out_ch    <= gnt;
        out_valid <= 1'b1;
        // Pointer advances past the winner only in round-robin; fixed
        // mode leaves it where RR last left it.
        if (mode == MODE_RR) begin
          ptr <= (gnt == SEL_W'(N_CH-1)) ? '0 : gnt + 1'b1;
        end
      end else if (drain) begin
        out_valid <= 1'b0;
      end
      if (drain) xfer_cnt <= xfer_cnt + 1'b1;
      sel_err <= (mode == MODE_FIXED) & !selOk;
    end
  end

  readyOneHot: assert property (@(posedge clk) $onehot0(in_ready));

endmodule

// File: tb/tb_mux_nx1_reg.sv
// Bench for mux_nx1_reg. dutA: N_CH=8, W=4 checked against a cycle-level
// model of the handshake rules. dutB: N_CH=5, W=3, CNT_W=4 for the
// out-of-range select and counter wrap cases.
module tb_mux_nx1_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int nTests = 0;
  int nFail  = 0;

  // ---------------- dutA ----------------
  logic        rstA = 1'b1;
  logic [31:0] inDataA = '0;
  logic [7:0]  inValidA = '0;
  logic [7:0]  readyA;
  logic        modeA = 1'b0;
  logic [2:0]  selA = '0;
  logic [3:0]  oDataA;
  logic [2:0]  oChA;
  logic        oValidA;
  logic        outReadyA = 1'b0;
  logic        selErrA;
  logic [15:0] cntA;

  mux_nx1_reg #(.N_CH(8), .W(4), .CNT_W(16)) dutA (
    .clk(clk), .rst(rstA), .in_data(inDataA), .in_valid(inValidA),
    .in_ready(readyA), .mode(modeA), .sel(selA), .out_data(oDataA),
    .out_ch(oChA), .out_valid(oValidA), .out_ready(outReadyA),
    .sel_err(selErrA), .xfer_cnt(cntA)
  );

  // ---------------- dutB ----------------
  logic        rstB = 1'b1;
  logic [14:0] inDataB = '0;
  logic [4:0]  inValidB = '0;
  logic [4:0]  readyB;
  logic        modeB = 1'b0;
  logic [2:0]  selB = '0;
  logic [2:0]  oDataB;
  logic [2:0]  oChB;
  logic        oValidB;
  logic        outReadyB = 1'b0;
  logic        selErrB;
  logic [3:0]  cntB;

  mux_nx1_reg #(.N_CH(5), .W(3), .CNT_W(4)) dutB (
    .clk(clk), .rst(rstB), .in_data(inDataB), .in_valid(inValidB),
    .in_ready(readyB), .mode(modeB), .sel(selB), .out_data(oDataB),
    .out_ch(oChB), .out_valid(oValidB), .out_ready(outReadyB),
    .sel_err(selErrB), .xfer_cnt(cntB)
  );

  // ---------------- reference model for dutA ----------------
  logic       mValid = 0;
  logic [3:0] mData = 0;
  int         mCh = 0;
  int         mPtr = 0;
  int         mCnt = 0;
  logic       mSelErr = 0;

  // Which channel would be granted now, from the mode rules.
  function automatic void grantA(output logic gv, output int g);
    int i;
    gv = 0;
    g  = 0;
    if (!modeA) begin
      g  = selA;
      gv = (selA < 8) && inValidA[selA];
    end else begin
      for (int k = 0; k < 8; k++) begin
        i = (mPtr + k) % 8;
        if (!gv && inValidA[i]) begin gv = 1; g = i; end
      end
    end
  endfunction

  function automatic logic [7:0] expReadyA();
    logic gv; int g;
    grantA(gv, g);
    if (rstA || !((!mValid || outReadyA) && gv)) return 8'h00;
    return 8'h01 << g;
  endfunction

  task automatic tickA();
    logic gv; int g; logic free;
    grantA(gv, g);
    free = !mValid || outReadyA;
    @(posedge clk);
    if (rstA) begin
      mValid = 0; mData = 0; mCh = 0; mPtr = 0; mCnt = 0; mSelErr = 0;
    end else begin
      if (mValid && outReadyA) mCnt = (mCnt + 1) % 65536;
      if (free && gv) begin
        mValid = 1;
        mData  = inDataA[g*4 +: 4];
        mCh    = g;
        if (modeA) mPtr = (g + 1) % 8;
      end else if (mValid && outReadyA) begin
        mValid = 0;
      end
      mSelErr = !modeA && (selA >= 8);
    end
    #1;
  endtask

  task automatic tickB();
    @(posedge clk);
    #1;
  endtask

  task automatic doRstA();
    rstA = 1; tickA(); rstA = 0;
  endtask

  task automatic doRstB();
    rstB = 1; tickB(); rstB = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rstA = 1; inValidA = 8'hFF; inDataA = $urandom; outReadyA = 0;
    for (int k = 0; k < 2; k++) begin
      #1;
      nTests++; if (readyA !== 8'h00) begin nFail++; $display("FAIL reset_ready: got %h exp 00", readyA); end
      tickA();
      nTests++; if (oValidA !== 1'b0) begin nFail++; $display("FAIL reset_valid: got %b exp 0", oValidA); end
      nTests++; if (cntA !== 16'd0) begin nFail++; $display("FAIL reset_cnt: got %0d exp 0", cntA); end
      nTests++; if (oDataA !== 4'd0 || oChA !== 3'd0) begin nFail++; $display("FAIL reset_data: got %h/%0d exp 0/0", oDataA, oChA); end
      nTests++; if (selErrA !== 1'b0) begin nFail++; $display("FAIL reset_selerr: got %b exp 0", selErrA); end
    end
    rstA = 0;
  endtask

  task automatic test_fixed();
    modeA = 0; selA = 3; inValidA = 8'hFF; inDataA = 32'h0000_1000; outReadyA = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      nTests++; if (readyA !== 8'h08) begin nFail++; $display("FAIL fixed_ready: got %h exp 08", readyA); end
      tickA();
      nTests++; if (oValidA !== 1'b1 || oChA !== 3'd3 || oDataA !== 4'd1) begin
        nFail++; $display("FAIL fixed_out: got v%b ch%0d d%h exp v1 ch3 d1", oValidA, oChA, oDataA); end
      nTests++; if (cntA !== 16'(k)) begin nFail++; $display("FAIL fixed_cnt: got %0d exp %0d", cntA, k); end
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] hd; int hc; int hn;
    hd = mData; hc = mCh; hn = mCnt;
    outReadyA = 0;
    for (int k = 0; k < 3; k++) begin
      selA = (k == 0) ? 3'd3 : 3'd6;
      inDataA = $urandom;
      #1;
      nTests++; if (readyA !== 8'h00) begin nFail++; $display("FAIL bp_ready: got %h exp 00", readyA); end
      tickA();
      nTests++; if (oValidA !== 1'b1 || oDataA !== hd || oChA !== 3'(hc)) begin
        nFail++; $display("FAIL bp_hold: got v%b ch%0d d%h exp v1 ch%0d d%h", oValidA, oChA, oDataA, hc, hd); end
      nTests++; if (cntA !== 16'(hn)) begin nFail++; $display("FAIL bp_cnt: got %0d exp %0d", cntA, hn); end
    end
    outReadyA = 1;
    #1;
    nTests++; if (readyA !== 8'h40) begin nFail++; $display("FAIL bp_release: got %h exp 40", readyA); end
    tickA();
  endtask

  task automatic test_rr();
    int chs[5] = '{0, 2, 5, 7, 0};
    doRstA();
    modeA = 1; inValidA = 8'b1010_0101; outReadyA = 1;
    for (int k = 0; k < 5; k++) begin
      inDataA = $urandom;
      #1;
      nTests++; if (readyA !== (8'h01 << chs[k])) begin nFail++; $display("FAIL rr_ready: got %h exp ch %0d", readyA, chs[k]); end
      tickA();
      nTests++; if (oChA !== 3'(chs[k]) || oValidA !== 1'b1 || oDataA !== mData) begin
        nFail++; $display("FAIL rr_seq: got ch%0d d%h exp ch%0d d%h", oChA, oDataA, chs[k], mData); end
    end
  endtask

  task automatic test_back_to_back();
    int prev;
    modeA = 1; inValidA = 8'hFF; outReadyA = 1;
    for (int k = 0; k < 12; k++) begin
      inDataA = $urandom;
      prev = mCnt;
      #1;
      nTests++; if (readyA !== expReadyA()) begin nFail++; $display("FAIL b2b_ready: got %h exp %h", readyA, expReadyA()); end
      tickA();
      nTests++; if (oValidA !== 1'b1 || oDataA !== mData || oChA !== 3'(mCh)) begin
        nFail++; $display("FAIL b2b_out: got ch%0d d%h exp ch%0d d%h", oChA, oDataA, mCh, mData); end
      nTests++; if (cntA !== 16'(prev + 1)) begin nFail++; $display("FAIL b2b_cnt: got %0d exp %0d", cntA, prev + 1); end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      rstA      = ($urandom_range(0, 49) == 0);
      inDataA   = $urandom;
      inValidA  = ($urandom_range(0, 3) == 0) ? 8'(($urandom & $urandom)) : 8'($urandom);
      if ($urandom_range(0, 7) == 0) modeA = ~modeA;
      selA      = 3'($urandom);
      outReadyA = ($urandom_range(0, 2) != 0);
      #1;
      nTests++; if (readyA !== expReadyA()) begin nFail++; $display("FAIL rnd_ready: cyc %0d got %h exp %h", k, readyA, expReadyA()); end
      tickA();
      nTests++; if (oValidA !== mValid || oDataA !== mData || oChA !== 3'(mCh)) begin
        nFail++; $display("FAIL rnd_out: cyc %0d got v%b ch%0d d%h exp v%b ch%0d d%h", k, oValidA, oChA, oDataA, mValid, mCh, mData); end
      nTests++; if (cntA !== 16'(mCnt) || selErrA !== mSelErr) begin
        nFail++; $display("FAIL rnd_cnt: cyc %0d got %0d/%b exp %0d/%b", k, cntA, selErrA, mCnt, mSelErr); end
    end
    rstA = 0;
  endtask

  task automatic test_sel_err();
    doRstB();
    modeB = 0; selB = 6; inValidB = 5'h1F; outReadyB = 1; inDataB = 15'd5 << 6;
    #1;
    nTests++; if (readyB !== 5'h00) begin nFail++; $display("FAIL selerr_ready: got %h exp 00", readyB); end
    tickB();
    nTests++; if (selErrB !== 1'b1 || oValidB !== 1'b0) begin nFail++; $display("FAIL selerr_set: got e%b v%b exp e1 v0", selErrB, oValidB); end
    selB = 2;
    #1;
    nTests++; if (readyB !== 5'b00100) begin nFail++; $display("FAIL selerr_ready2: got %h exp 04", readyB); end
    tickB();
    nTests++; if (selErrB !== 1'b0 || oValidB !== 1'b1 || oChB !== 3'd2 || oDataB !== 3'd5) begin
      nFail++; $display("FAIL selerr_clr: got e%b v%b ch%0d d%0d exp e0 v1 ch2 d5", selErrB, oValidB, oChB, oDataB); end
    selB = 7; modeB = 1;
    tickB();
    nTests++; if (selErrB !== 1'b0) begin nFail++; $display("FAIL selerr_rrmode: got %b exp 0", selErrB); end
  endtask

  task automatic test_cnt_wrap();
    doRstB();
    modeB = 1; inValidB = 5'h1F; outReadyB = 1; inDataB = 15'h7FFF;
    repeat (17) tickB();
    nTests++; if (cntB !== 4'd0) begin nFail++; $display("FAIL cnt_wrap16: got %0d exp 0", cntB); end
    tickB();
    nTests++; if (cntB !== 4'd1 || oValidB !== 1'b1) begin nFail++; $display("FAIL cnt_wrap17: got %0d v%b exp 1 v1", cntB, oValidB); end
    rstB = 1;
    #1;
    nTests++; if (readyB !== 5'h00) begin nFail++; $display("FAIL cnt_rst_ready: got %h exp 00", readyB); end
    tickB();
    nTests++; if (oValidB !== 1'b0 || cntB !== 4'd0 || oDataB !== 3'd0 || oChB !== 3'd0) begin
      nFail++; $display("FAIL cnt_rst: got v%b c%0d d%0d ch%0d exp all 0", oValidB, cntB, oDataB, oChB); end
    rstB = 0;
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_backpressure();
    test_rr();
    test_back_to_back();
    test_random();
    test_sel_err();
    test_cnt_wrap();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
